binary_dense_layer: RTL and testbench

Binarized fully-connected output layer that sits directly downstream of the pooling stage. It consumes 4-pixel groups of binarized activations (8'h01 = +1, 8'hff = -1) over one image, and forms an XNOR-style signed dot product per output neuron against 1-bit stored weights. Once the image is complete it reports the winning class and its score over a valid/ready handshake.

---
 rtl/binary_dense_layer.sv | 160 ++++++++++++++++
 tb/tb_binary_dense_layer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_dense_layer.sv
// Binarized dense output layer: accumulates XNOR-style signed dot products of
// 4-pixel activation groups against 1-bit weights for every output neuron,
// then presents the argmax class and its score over a valid/ready handshake.
module binary_dense_layer #(
    parameter int N_GROUPS = 4,
    parameter int N_OUT    = 2,
    parameter int ACC_W    = 6
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [3:0][7:0]                     pooled_pixels,
    input  logic                                w_we,
    input  logic [$clog2(N_OUT*N_GROUPS)-1:0]   w_addr,
    input  logic [3:0]                          w_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(N_OUT)-1:0]            out_class,
    output logic signed [ACC_W-1:0]             out_score
);

    localparam int DEPTH = N_OUT * N_GROUPS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(N_OUT);
    localparam int GW    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                          state_reg;
    state_t                          state_next;
    logic [GW-1:0]                   group_cnt_reg;
    logic [N_OUT-1:0][ACC_W-1:0]     acc_reg;
    logic [N_OUT-1:0][ACC_W-1:0]     delta;
    logic [3:0]                      wmem [DEPTH];
    logic [3:0]                      pix_sign;
    logic                            accept;
    logic                            last_group;
    logic                            result_taken;
    logic [CW-1:0]                   best_idx;
    logic signed [ACC_W-1:0]         best_val;

    assign accept       = in_valid && in_ready;
    assign last_group   = (group_cnt_reg == GW'(N_GROUPS - 1));
    assign result_taken = (state_reg == ST_HOLD) && out_ready;

    // Sign bit of each activation: 1 means -1, 0 means +1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pix
            assign pix_sign[gi] = pooled_pixels[gi][7];
        end
    endgenerate

    // Per-neuron beat delta: each pixel/weight agreement adds +1, each
    // disagreement -1, so delta = 2*matches - 4. A weight bit of 1 (+1)
    // agrees with sign 0 (+1), hence match = weight ^ sign.
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_neuron
            localparam logic [AW-1:0] BASE = AW'(gi * N_GROUPS);
            logic [AW-1:0] rd_addr;
            logic [3:0]    w_word;
            logic [3:0]    match;
            logic [2:0]    match_cnt;

            assign rd_addr   = BASE + AW'(group_cnt_reg);
            assign w_word    = wmem[rd_addr];
            assign match     = w_word ^ pix_sign;
            assign match_cnt = 3'(match[0]) + 3'(match[1]) + 3'(match[2]) + 3'(match[3]);
            assign delta[gi] = ACC_W'({match_cnt, 1'b0}) - ACC_W'(4);
        end
    endgenerate

    // Weight RAM: writable only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_we && (state_reg == ST_IDLE) && (int'(w_addr) < DEPTH)) begin
            wmem[w_addr] <= w_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides any accept or handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_next = last_group ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // Group counter wraps to zero on the last group of an image.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            group_cnt_reg <= '0;
        end else if (accept) begin
            group_cnt_reg <= last_group ? '0 : group_cnt_reg + GW'(1);
        end
    end

    // Accumulators: cleared on reset, flush or when the result is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || result_taken) begin
            acc_reg <= '0;
        end else if (accept) begin
            for (int n = 0; n < N_OUT; n++) begin
                acc_reg[n] <= acc_reg[n] + delta[n];
            end
        end
    end

    // Argmax with strict compare so ties resolve to the lower index.
    always_comb begin
        best_idx = '0;
        best_val = $signed(acc_reg[0]);
        for (int n = 1; n < N_OUT; n++) begin
            if ($signed(acc_reg[n]) > best_val) begin
                best_idx = CW'(n);
                best_val = $signed(acc_reg[n]);
            end
        end
    end

    // Outputs depend only on state so in_ready has no path from in_valid.
    always_comb begin
        in_ready  = (state_reg != ST_HOLD);
        out_valid = (state_reg == ST_HOLD);
        out_class = '0;
        out_score = '0;
        if (state_reg == ST_HOLD) begin
            out_class = best_idx;
            out_score = best_val;
        end
    end

endmodule

// File: tb/tb_binary_dense_layer.sv
// Randomized self-checking bench for binary_dense_layer against a signed
// product-sum reference model.
module tb_binary_dense_layer;

    localparam int N_GROUPS = 4;
    localparam int N_OUT    = 2;
    localparam int ACC_W    = 6;
    localparam int AW       = $clog2(N_OUT * N_GROUPS);
    localparam int CW       = $clog2(N_OUT);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0][7:0]         pooled_pixels;
    logic                    w_we;
    logic [AW-1:0]           w_addr;
    logic [3:0]              w_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           out_class;
    logic signed [ACC_W-1:0] out_score;

    int total = 0;
    int bad   = 0;

    logic [3:0][7:0] img [N_GROUPS];
    logic [3:0]      mw  [N_OUT][N_GROUPS];
    int              exp_cls;
    int              exp_score;

    binary_dense_layer #(.N_GROUPS(N_GROUPS), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pooled_pixels(pooled_pixels),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_score(out_score)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of sign(pixel) * sign(weight), argmax lowest index.
    task automatic compute_expected();
        int a [N_OUT];
        for (int n = 0; n < N_OUT; n++) begin
            a[n] = 0;
            for (int g = 0; g < N_GROUPS; g++) begin
                for (int k = 0; k < 4; k++) begin
                    a[n] += (img[g][k][7] ? -1 : 1) * (mw[n][g][k] ? 1 : -1);
                end
            end
        end
        exp_cls   = 0;
        exp_score = a[0];
        for (int n = 1; n < N_OUT; n++) begin
            if (a[n] > exp_score) begin
                exp_cls   = n;
                exp_score = a[n];
            end
        end
    endtask

    task automatic write_w(input int n, input int g, input logic [3:0] d);
        w_we   = 1'b1;
        w_addr = AW'(n * N_GROUPS + g);
        w_data = d;
        step();
        w_we   = 1'b0;
        mw[n][g] = d;
    endtask

    task automatic set_weights(input logic [3:0] d0, input logic [3:0] d1);
        for (int g = 0; g < N_GROUPS; g++) begin
            write_w(0, g, d0);
            write_w(1, g, d1);
        end
    endtask

    task automatic fill_img(input logic [3:0][7:0] v);
        for (int g = 0; g < N_GROUPS; g++) img[g] = v;
    endtask

    task automatic rand_img();
        for (int g = 0; g < N_GROUPS; g++)
            for (int k = 0; k < 4; k++) img[g][k] = 8'($urandom);
    endtask

    task automatic drive_image();
        for (int g = 0; g < N_GROUPS; g++) begin
            in_valid      = 1'b1;
            pooled_pixels = img[g];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        total++;
        if (out_class !== '0 || out_score !== '0) begin
            bad++;
            $display("FAIL reset_out class=%0d score=%0d required 0/0", out_class, out_score);
        end
    endtask

    task automatic test_basic();
        set_weights(4'hF, 4'h0);
        for (int pass = 0; pass < 2; pass++) begin
            fill_img(pass == 0 ? {4{8'h01}} : {4{8'hff}});
            compute_expected();
            drive_image();
            total++;
            if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
                bad++;
                $display("FAIL basic%0d valid=%b class=%0d score=%0d required 1/%0d/%0d",
                         pass, out_valid, out_class, out_score, exp_cls, exp_score);
            end
            $display("basic%0d class=%0d score=%0d", pass, out_class, out_score);
            take_result();
            total++;
            if (out_valid !== 1'b0 || out_score !== '0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic%0d_release valid=%b score=%0d ready=%b required 0/0/1",
                         pass, out_valid, out_score, in_ready);
            end
        end
    endtask

    task automatic test_pattern();
        set_weights(4'hA, 4'h5);
        for (int pass = 0; pass < 2; pass++) begin
            fill_img(pass == 0 ? {8'hff, 8'h01, 8'hff, 8'h01} : {4{8'h01}});
            compute_expected();
            drive_image();
            total++;
            if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
                bad++;
                $display("FAIL pattern%0d valid=%b class=%0d score=%0d required 1/%0d/%0d",
                         pass, out_valid, out_class, out_score, exp_cls, exp_score);
            end
            $display("pattern%0d class=%0d score=%0d", pass, out_class, out_score);
            take_result();
        end
    endtask

    task automatic test_backpressure();
        rand_img();
        compute_expected();
        drive_image();
        for (int c = 0; c < 5; c++) begin
            in_valid      = 1'b1;
            pooled_pixels = 32'($urandom);
            step();
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
                bad++;
                $display("FAIL hold_c%0d ready=%b valid=%b class=%0d score=%0d required 0/1/%0d/%0d",
                         c, in_ready, out_valid, out_class, out_score, exp_cls, exp_score);
            end
        end
        in_valid = 1'b0;
        take_result();
        rand_img();
        compute_expected();
        drive_image();
        total++;
        if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
            bad++;
            $display("FAIL after_hold class=%0d score=%0d required %0d/%0d",
                     out_class, out_score, exp_cls, exp_score);
        end
        $display("after_hold class=%0d score=%0d", out_class, out_score);
        take_result();
    endtask

    task automatic test_flush();
        for (int g = 0; g < 2; g++) begin
            in_valid      = 1'b1;
            pooled_pixels = 32'($urandom);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        rand_img();
        compute_expected();
        drive_image();
        total++;
        if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
            bad++;
            $display("FAIL flush_partial valid=%b class=%0d score=%0d required 1/%0d/%0d",
                     out_valid, out_class, out_score, exp_cls, exp_score);
        end
        $display("flush_partial class=%0d score=%0d", out_class, out_score);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_score !== '0) begin
            bad++;
            $display("FAIL flush_hold valid=%b ready=%b score=%0d required 0/1/0",
                     out_valid, in_ready, out_score);
        end
    endtask

    task automatic test_wwrite_accum();
        logic [3:0] new_w;
        set_weights(4'(($urandom)), 4'($urandom));
        rand_img();
        new_w = ~mw[0][0];
        compute_expected();
        // First beat carries a write to n0/g0: old weight used, write commits.
        for (int g = 0; g < N_GROUPS; g++) begin
            in_valid      = 1'b1;
            pooled_pixels = img[g];
            w_we          = 1'b1;
            w_addr        = (g == 0) ? AW'(0) : AW'(g);
            w_data        = (g == 0) ? new_w : 4'h0;
            step();
        end
        in_valid = 1'b0;
        w_we     = 1'b0;
        mw[0][0] = new_w;
        total++;
        if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
            bad++;
            $display("FAIL wwrite_accum class=%0d score=%0d required %0d/%0d",
                     out_class, out_score, exp_cls, exp_score);
        end
        $display("wwrite_accum class=%0d score=%0d", out_class, out_score);
        take_result();
        rand_img();
        compute_expected();
        drive_image();
        total++;
        if (int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
            bad++;
            $display("FAIL wwrite_commit class=%0d score=%0d required %0d/%0d",
                     out_class, out_score, exp_cls, exp_score);
        end
        $display("wwrite_commit class=%0d score=%0d", out_class, out_score);
        take_result();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int wait_c;
            for (int n = 0; n < N_OUT; n++)
                for (int g = 0; g < N_GROUPS; g++) write_w(n, g, 4'($urandom));
            rand_img();
            compute_expected();
            drive_image();
            total++;
            if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
                bad++;
                $display("FAIL random%0d valid=%b class=%0d score=%0d required 1/%0d/%0d",
                         it, out_valid, out_class, out_score, exp_cls, exp_score);
            end
            $display("random%0d class=%0d score=%0d", it, out_class, out_score);
            wait_c = $urandom_range(0, 3);
            for (int c = 0; c < wait_c; c++) step();
            take_result();
        end
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 2; g++) begin
            in_valid      = 1'b1;
            pooled_pixels = 32'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== '0 || out_score !== '0) begin
            bad++;
            $display("FAIL reset_mid valid=%b ready=%b class=%0d score=%0d required 0/1/0/0",
                     out_valid, in_ready, out_class, out_score);
        end
        rand_img();
        compute_expected();
        drive_image();
        total++;
        if (out_valid !== 1'b1 || int'(out_class) !== exp_cls || int'(out_score) !== exp_score) begin
            bad++;
            $display("FAIL reset_keep_w class=%0d score=%0d required %0d/%0d",
                     out_class, out_score, exp_cls, exp_score);
        end
        $display("reset_keep_w class=%0d score=%0d", out_class, out_score);
        take_result();
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        pooled_pixels = '0;
        w_we          = 1'b0;
        w_addr        = '0;
        w_data        = '0;
        out_ready     = 1'b0;
        test_reset();
        test_basic();
        test_pattern();
        test_backpressure();
        test_flush();
        test_wwrite_accum();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
